// File: rtl/serv_mac_mul.sv
// Bit-serial multiply stage feeding the ALU MAC path.
// Captures rs1/op_b W bits per cycle, forms the low 32 bits of rs1*op_b with a
// 32-cycle shift-and-add loop, then streams the product LSB-first on o_buf.
//
// Ports:
//   clk          clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      one-cycle multiply request, honoured only when idle
//   i_en         serial-bus advance strobe
//   i_rs1        multiplicand slice, LSB-first
//   i_op_b       multiplier slice, LSB-first
//   o_buf        product slice to the ALU (zero outside the output phase)
//   o_mac_step2  high while the product is streaming
//   o_busy       high whenever not idle
//   o_done       one-cycle pulse after the last product slice is accepted
module serv_mac_mul #(
   parameter int unsigned W = 1,
   parameter int unsigned B = W - 1
) (
   input  logic       clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_en,
   input  logic [B:0] i_rs1,
   input  logic [B:0] i_op_b,
   output logic [B:0] o_buf,
   output logic       o_mac_step2,
   output logic       o_busy,
   output logic       o_done
);

   localparam int unsigned NSLICE     = 32 / W;
   localparam logic [4:0]  LAST_SLICE = 5'(NSLICE - 1);
   localparam logic [4:0]  LAST_MUL   = 5'd31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MUL  = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [31:0] a, a_n;
   logic [31:0] m, m_n;
   logic [31:0] acc, acc_n;
   logic [4:0]  cnt, cnt_n;
   logic        done_n;

   // State, datapath registers and registered outputs.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         a           <= '0;
         m           <= '0;
         acc         <= '0;
         cnt         <= '0;
         o_buf       <= '0;
         o_mac_step2 <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         state       <= state_n;
         a           <= a_n;
         m           <= m_n;
         acc         <= acc_n;
         cnt         <= cnt_n;
         // Outputs are decoded from next-state values so they line up with
         // the state they describe.
         o_buf       <= (state_n == OUT) ? acc_n[B:0] : '0;
         o_mac_step2 <= (state_n == OUT);
         o_busy      <= (state_n != IDLE);
         o_done      <= done_n;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_n = state;
      a_n     = a;
      m_n     = m;
      acc_n   = acc;
      cnt_n   = cnt;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               state_n = LOAD;
               cnt_n   = '0;
               acc_n   = '0;
            end
         end
         LOAD: begin
            if (i_en) begin
               a_n   = {i_rs1, a[31:W]};
               m_n   = {i_op_b, m[31:W]};
               cnt_n = cnt + 5'd1;
               if (cnt == LAST_SLICE) begin
                  state_n = MUL;
                  cnt_n   = '0;
               end
            end
         end
         MUL: begin
            // Fixed 32 iterations regardless of i_en; m is consumed LSB first.
            if (m[0]) begin
               acc_n = acc + a;
            end
            a_n   = a << 1;
            m_n   = m >> 1;
            cnt_n = cnt + 5'd1;
            if (cnt == LAST_MUL) begin
               state_n = OUT;
               cnt_n   = '0;
            end
         end
         OUT: begin
            if (i_en) begin
               acc_n = acc >> W;
               cnt_n = cnt + 5'd1;
               if (cnt == LAST_SLICE) begin
                  state_n = IDLE;
                  cnt_n   = '0;
                  done_n  = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serv_mac_mul.sv
// Self-checking bench for serv_mac_mul: one W=1 and one W=4 instance,
// scoreboard of expected products, timing and protocol checks per operation.
module tb_serv_mac_mul;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start1, en1;
   logic [0:0] rs1_1, opb_1, buf1;
   logic       step1, busy1, done1;

   logic       start4, en4;
   logic [3:0] rs1_4, opb_4, buf4;
   logic       step4, busy4, done4;

   serv_mac_mul #(.W(1), .B(0)) u_w1 (
      .clk(clk), .i_rst(rst), .i_start(start1), .i_en(en1),
      .i_rs1(rs1_1), .i_op_b(opb_1), .o_buf(buf1),
      .o_mac_step2(step1), .o_busy(busy1), .o_done(done1)
   );

   serv_mac_mul #(.W(4), .B(3)) u_w4 (
      .clk(clk), .i_rst(rst), .i_start(start4), .i_en(en4),
      .i_rs1(rs1_4), .i_op_b(opb_4), .o_buf(buf4),
      .o_mac_step2(step4), .o_busy(busy4), .o_done(done4)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive one instance; k selects which operand slice is presented.
   task automatic set_in(input int w, input logic s, input logic e,
                         input logic [31:0] x, input logic [31:0] y, input int k);
      if (w == 1) begin
         start1 = s; en1 = e;
         rs1_1 = 1'(x >> k);
         opb_1 = 1'(y >> k);
      end else begin
         start4 = s; en4 = e;
         rs1_4 = 4'(x >> (4 * k));
         opb_4 = 4'(y >> (4 * k));
      end
   endtask

   task automatic get_out(input int w, output logic step, output logic busy,
                          output logic done, output logic [3:0] b);
      if (w == 1) begin
         step = step1; busy = busy1; done = done1; b = {3'b000, buf1};
      end else begin
         step = step4; busy = busy4; done = done4; b = buf4;
      end
   endtask

   // One full multiply; inputs set on negedge, outputs observed on negedge.
   task automatic run_op(input int w, input logic [31:0] x, input logic [31:0] y,
                         input bit toggle, input bit extra, input string name);
      int nsl, k, load_end, first_s, last_s, done_c, ndone, bad_idle, hold_err, nacc, c;
      logic [31:0] prod, exp;
      logic [3:0]  b, prev_buf;
      logic        step, busy, done, prev_step, prev_en, e, s;
      nsl = 32 / w; k = 0; load_end = -1; first_s = -1; last_s = -1;
      done_c = -1; ndone = 0; bad_idle = 0; hold_err = 0; nacc = 0;
      prod = '0; prev_buf = '0; prev_step = 1'b0; prev_en = 1'b0;
      exp_q.push_back(x * y);
      @(negedge clk);
      set_in(w, 1'b1, 1'b1, x, y, 0);
      for (c = 1; c < 400; c++) begin
         @(negedge clk);
         get_out(w, step, busy, done, b);
         if (c == 1) check({name, " busy_load"}, 32'(busy), 32'd1);
         if (step) begin
            if (first_s < 0) first_s = c;
            last_s = c;
            if (prev_step && !prev_en && b !== prev_buf) hold_err++;
         end else if (b !== 4'd0) begin
            bad_idle++;
         end
         if (done) begin
            ndone++;
            if (done_c < 0) begin
               done_c = c;
               check({name, " busy_at_done"}, 32'(busy), 32'd0);
            end
         end
         if (done_c >= 0 && c == done_c + 3) break;
         e = toggle ? 1'(c % 2) : 1'b1;
         s = extra && (c == 5 || (load_end >= 0 && c == load_end + 10));
         if (step && e) begin
            prod = prod | (32'(b) << (w * nacc));
            nacc++;
            if (nacc == nsl) begin
               check({name, " sb_nonempty"}, 32'(exp_q.size()), 32'd1);
               if (exp_q.size() > 0) begin
                  exp = exp_q.pop_front();
                  check({name, " product"}, prod, exp);
               end
            end
         end
         set_in(w, s, e, x, y, k);
         if (e && k < nsl) begin
            k++;
            if (k == nsl) load_end = c;
         end
         prev_step = step; prev_en = e; prev_buf = b;
      end
      set_in(w, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      check({name, " slices"}, 32'(nacc), 32'(nsl));
      check({name, " mul_len"}, 32'(first_s), 32'(load_end + 33));
      check({name, " done_after_last"}, 32'(done_c), 32'(last_s + 1));
      check({name, " done_count"}, 32'(ndone), 32'd1);
      check({name, " buf_zero_outside"}, 32'(bad_idle), 32'd0);
      check({name, " buf_hold"}, 32'(hold_err), 32'd0);
      check({name, " idle_after"}, 32'(busy), 32'd0);
      if (!toggle) begin
         check({name, " first_out"}, 32'(first_s), 32'(1 + nsl + 32));
         check({name, " done_cycle"}, 32'(done_c), 32'(1 + nsl + 32 + nsl));
      end
   endtask

   // Abort a W=1 multiply mid-output with an asynchronous reset.
   task automatic reset_mid_out();
      int seen, nacc;
      nacc = 0;
      @(negedge clk);
      set_in(1, 1'b1, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 0);
      for (int c = 1; c < 200 && nacc < 10; c++) begin
         @(negedge clk);
         if (step1) nacc++;
         set_in(1, 1'b0, 1'b1, 32'h0000FFFF, 32'h0000FFFF, c);
      end
      @(negedge clk);
      check("rst step2_before", 32'(step1), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst step2_async", 32'(step1), 32'd0);
      check("rst busy_async", 32'(busy1), 32'd0);
      check("rst buf_async", 32'(buf1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy1 || step1 || done1 || buf1 != 1'b0) seen++;
      end
      set_in(1, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      check("rst quiet_after", 32'(seen), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      set_in(1, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      set_in(4, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      #12;
      check("reset w1 outs", {28'd0, buf1, step1, busy1, done1}, 32'd0);
      check("reset w4 outs", {25'd0, buf4, step4, busy4, done4}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(1, 32'd3, 32'd5, 1'b0, 1'b0, "w1_3x5");
      run_op(4, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "w4_ones");
      run_op(1, 32'h00010000, 32'h00010000, 1'b0, 1'b0, "w1_trunc");
      run_op(4, 32'h12345678, 32'h00000009, 1'b1, 1'b0, "w4_toggle");
      run_op(4, 32'h00001234, 32'h00005678, 1'b0, 1'b1, "w4_ignore_start");
      run_op(1, 32'hDEADBEEF, 32'h0BADF00D, 1'b0, 1'b1, "w1_ignore_start");
      for (int i = 0; i < 2; i++) begin
         run_op(4, $urandom, $urandom, 1'(i), 1'b0, "w4_rand");
      end
      reset_mid_out();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
